// File: rtl/rv32i_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// load/store unit and data memory; one 32-bit word per line.
package rv32i_package;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_res_type;
endpackage

module rv32i_dcache
    import rv32i_package::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  cpu_req_type cpu_req,
    output cpu_res_type cpu_res,
    output cpu_req_type mem_req,
    input  cpu_res_type mem_res
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_COMPARE       = 3'd1,
        S_ALLOCATE      = 3'd2,
        S_WRITE_THROUGH = 3'd3,
        S_RESPOND       = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [29:0]       r_word;
    logic [31:0]       r_wdata;
    logic              r_rw;
    logic [31:0]       r_rdata;
    logic [LINES-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag  [LINES];
    logic [31:0]       r_data [LINES];

    logic [IDX-1:0]    w_idx;
    logic [TAGW-1:0]   w_tag;
    logic              w_hit;
    logic              w_fill;
    logic              w_write_hit;
    logic              w_read_hit;
    logic              w_unused_lsbs;

    // Byte offset is irrelevant for word-sized lines.
    assign w_unused_lsbs = ^cpu_req.addr[1:0];

    assign w_idx       = r_word[IDX-1:0];
    assign w_tag       = r_word[29:IDX];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill      = (r_state == S_ALLOCATE) && mem_res.ready;
    assign w_write_hit = (r_state == S_COMPARE) && r_rw && w_hit;
    assign w_read_hit  = (r_state == S_COMPARE) && !r_rw && w_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_req.valid) begin
                    w_next = S_COMPARE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (r_rw) begin
                    w_next = S_WRITE_THROUGH;
                end else if (w_hit) begin
                    w_next = S_RESPOND;
                end else begin
                    w_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE, S_WRITE_THROUGH: begin
                if (mem_res.ready) begin
                    w_next = S_RESPOND;
                end else begin
                    w_next = r_state;
                end
            end
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Request capture and read-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= 30'd0;
            r_wdata <= 32'd0;
            r_rw    <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && cpu_req.valid) begin
                r_word  <= cpu_req.addr[31:2];
                r_wdata <= cpu_req.data;
                r_rw    <= cpu_req.rw;
            end
            if (w_read_hit) begin
                r_rdata <= r_data[w_idx];
            end else if (w_fill) begin
                r_rdata <= mem_res.data;
            end
        end
    end

    // Line valid bits; only a fill sets one, only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_res.data;
        end else if (w_write_hit) begin
            r_data[w_idx] <= r_wdata;
        end
    end

    // Outputs decode from registers only, so reset drops them at once.
    always_comb begin
        cpu_res       = '0;
        cpu_res.data  = r_rdata;
        cpu_res.ready = (r_state == S_RESPOND);
        mem_req       = '0;
        if (r_state == S_ALLOCATE) begin
            mem_req.addr  = {r_word, 2'b00};
            mem_req.valid = 1'b1;
        end else if (r_state == S_WRITE_THROUGH) begin
            mem_req.addr  = {r_word, 2'b00};
            mem_req.data  = r_wdata;
            mem_req.rw    = 1'b1;
            mem_req.valid = 1'b1;
        end else begin
            mem_req.valid = 1'b0;
        end
    end
endmodule

// File: doc/rv32i_dcache.md
# rv32i_dcache

Direct-mapped, write-through, no-write-allocate data cache controller that responds to the CPU-side `cpu_req_type` / `cpu_res_type` request/response pair from `rv32i_package`. It sits between the core's load/store unit and data memory. It issues misses and all writes downstream on a memory port that reuses the same two types.

## Interface
- `LINES`, 64: number of one-word cache lines. Power of 2, ≥2. `IDX = log2(LINES)`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_req` in `cpu_req_type` (66): request from the CPU. Fields are `addr`, `data`, `rw` (1 = write) and `valid`.
- `cpu_res` out `cpu_res_type` (33): response to the CPU. Fields are `data` and `ready`.
- `mem_req` out `cpu_req_type` (66): request to data memory.
- `mem_res` in `cpu_res_type` (33): response from data memory.

## Operation
- **Address split:** `addr[1:0]` is ignored; index = `addr[2+:IDX]`; tag = `addr[31:2+IDX]`.
- **Storage:**
  - per-line valid bit, cleared by reset;
  - tag array and data array, not reset.
- **States:** IDLE, COMPARE, ALLOCATE, WRITE_THROUGH, RESPOND.
- **IDLE:** if `cpu_req.valid`, capture addr/data/rw into internal registers and go to COMPARE.
- **COMPARE:** hit = valid[idx] && tag match.
  - Read hit: register `cpu_res.data` = data[idx], then go to RESPOND.
  - Read miss: go to ALLOCATE.
  - Write hit: update data[idx] with the write data this cycle, then go to WRITE_THROUGH.
  - Write miss: go to WRITE_THROUGH; cache contents are unchanged.
- **ALLOCATE:**
  - Drives `mem_req` = {addr with [1:0]=0, data 0, rw 0, valid 1}.
  - On `mem_res.ready`: set valid[idx]=1, write the tag, write data = `mem_res.data`, register `cpu_res.data` = `mem_res.data`, then go to RESPOND.
- **WRITE_THROUGH:**
  - Drives `mem_req` = {word-aligned addr, captured write data, rw 1, valid 1}.
  - On `mem_res.ready`: go to RESPOND. `cpu_res.data` is don't-care for writes and holds its previous value.
- **RESPOND:** `cpu_res.ready`=1 for exactly this one cycle, then go to IDLE.
- **CPU handshake:**
  - CPU holds `cpu_req` stable from the first valid cycle until it sees `cpu_res.ready`.
  - In the cycle after ready, CPU either drops `valid` or presents a new request; this is when the FSM is back in IDLE.
  - `cpu_req.valid` outside IDLE is ignored.
- **Memory handshake:**
  - `mem_req.valid` = state ∈ {ALLOCATE, WRITE_THROUGH}. Its fields come from the captured registers and are stable while valid.
  - Memory may assert the single-cycle `mem_res.ready` in any cycle where `mem_req.valid`=1, including the first one.
  - `mem_res.ready` while `mem_req.valid`=0 is ignored.
- **Reset values:** `cpu_res` = 0, `mem_req` = 0, state IDLE, all valid bits 0.
- **Reset mid-operation:** assertion at any point forces IDLE and clears all valid bits. `mem_req.valid` and `cpu_res.ready` drop immediately (asynchronously). The in-flight request is abandoned, and the CPU must reissue it.
- **Conflicts:** a read miss to an index holding a different tag replaces that line. With write-through there is no dirty state and no writeback.
- **Read-after-write:** a read hit after a write hit to the same address returns the new data.

## Timing
- Cycle N is the first cycle with `cpu_req.valid`=1 while in IDLE.
- COMPARE occurs in N+1.
- Read hit: `cpu_res.ready` is high in N+2.
- Read miss / any write:
  - `mem_req.valid` is high from N+2.
  - If memory responds after W wait cycles (W=0 means ready in the first valid cycle), `cpu_res.ready` is high in N+3+W.
- `mem_req.valid` falls in the cycle after `mem_res.ready` is sampled.
- Minimum issue interval: a read hit every 3 cycles.

## Test plan
- **Cold read miss:** release reset, then read 0x100 while memory returns 0xDEADBEEF with W=3.
  - `mem_req` shows addr 0x100, rw 0 for 4 cycles.
  - `cpu_res.ready` is a single pulse in N+6 with data 0xDEADBEEF.
- **Read hit:** re-read 0x100.
  - `cpu_res.ready` in N+2 with data 0xDEADBEEF.
  - `mem_req.valid` never rises.
- **Write hit:** write 0x12345678 to 0x102.
  - `mem_req` shows addr 0x100, data 0x12345678, rw 1.
  - A following read of 0x100 hits in N+2 with data 0x12345678.
- **Write miss, no allocate:** write 0xCAFEF00D to 0x204 with W=0.
  - Ready in N+3.
  - A subsequent read of 0x204 still misses and issues a memory read.
- **Conflict eviction (LINES=64):** read 0x100, then 0x200 (same index, different tag), then 0x100.
  - All three reads miss and each issues a memory read.
  - Each returns the memory data for its own address.
- **Reset during ALLOCATE:** pulse `rst` while `mem_req.valid`=1.
  - `mem_req.valid` and `cpu_res.ready` drop without waiting for a clock edge.
  - The previously cached 0x100 misses afterwards.
